kvadd_stream_alu: RTL and testbench
===================================

# kvadd_stream_alu

Parametrised multi-lane streaming ALU stage for the vadd kernel datapath. It sits between the AXI4 read master stream and the AXI4 write master stream. Each accepted beat is split into independent lanes, and every lane is combined with a runtime constant using a selectable operation. The block counts beats against the programmed transfer size, generates its own `tlast`, and pulses `ctrl_done` once the final beat has left the pipeline.

## Interface
- `C_AXIS_TDATA_WIDTH`, 512: stream data width in bits; must be a multiple of `C_LANE_WIDTH`.
- `C_LANE_WIDTH`, 32: lane width; legal values are 8, 16, 32 or 64.
- `C_XFER_SIZE_WIDTH`, 32: width of the transfer-size input.
- `C_PIPE_STAGES`, 2: pipeline depth, 1..4.
- `aclk` in 1: single clock for all logic.
- `areset` in 1: asynchronous, active-high reset.
- `ctrl_start` in 1: start request; sampled only in IDLE.
- `ctrl_done` out 1: one-cycle completion pulse.
- `ctrl_mode` in 2: operation select. 0 = add, 1 = sub, 2 = saturating unsigned add, 3 = pass-through.
- `ctrl_constant` in `C_LANE_WIDTH`: per-lane operand.
- `ctrl_xfer_size_in_bytes` in `C_XFER_SIZE_WIDTH`: transfer length in bytes.
- `s_axis_tvalid` in 1, `s_axis_tready` out 1, `s_axis_tdata` in `C_AXIS_TDATA_WIDTH`, `s_axis_tlast` in 1: input stream.
- `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tdata` out `C_AXIS_TDATA_WIDTH`, `m_axis_tlast` out 1: output stream.
- `stat_tlast_err` out 1: sticky flag; input `tlast` disagreed with the computed final beat.

## Operation
- **Beat count.**
  - Bytes per beat B = `C_AXIS_TDATA_WIDTH`/8.
  - N = ceil(size/B), computed at start.
  - `ctrl_mode`, `ctrl_constant` and N are latched at start; input changes during a run are ignored.
- **State machine.**
  - IDLE: on `ctrl_start`, latch the controls, clear `stat_tlast_err` and the counters. Go to DONE if N == 0, else to RUN.
  - RUN: `s_axis_tready` = pipeline advance enable. On the N-th input handshake, go to DRAIN.
  - DRAIN: `s_axis_tready` = 0. On the output handshake carrying `m_axis_tlast`, go to DONE.
  - DONE: `ctrl_done` = 1 for exactly one cycle, then go to IDLE.
- **Start handling.** `ctrl_start` in any state other than IDLE is ignored; it is not queued.
- **Pipeline.**
  - `C_PIPE_STAGES` registered stages, each carrying a valid bit, data and last.
  - Global advance enable = `!m_axis_tvalid || m_axis_tready`. The whole pipeline stalls together, and bubbles are not collapsed.
  - Lane arithmetic is done in stage 1; later stages are delay registers.
- **Lane arithmetic** (lane i = bits [i·W +: W], W = `C_LANE_WIDTH`):
  - add: (x + c) mod 2^W.
  - sub: (x − c) mod 2^W.
  - sat: min(x + c, 2^W − 1), using a W+1-bit sum.
  - pass: x.
- **Output `tlast`.** `m_axis_tlast` is generated from the input beat counter: it is set on the N-th accepted beat. Input `s_axis_tlast` is never forwarded.
- **`tlast` error check.** `stat_tlast_err` is set when `s_axis_tlast` = 1 on beat k < N, or when `s_axis_tlast` = 0 on beat N. It holds until the next accepted start.
- **Counters.** The beat counters are `C_XFER_SIZE_WIDTH` bits wide. The N computation must not overflow for size = 2^`C_XFER_SIZE_WIDTH` − 1.

## Timing
- **Reset values:** `s_axis_tready`, `m_axis_tvalid`, `m_axis_tlast`, `ctrl_done` and `stat_tlast_err` are 0; `m_axis_tdata` is 0; state is IDLE.
- **Latency:** input handshake at cycle t gives `m_axis_tvalid` at t + `C_PIPE_STAGES`, with no stall.
- **Throughput:** 1 beat/cycle while `m_axis_tready` = 1.
- **Handshake stability:** `m_axis_tdata`, `m_axis_tlast` and `m_axis_tvalid` stay stable while `m_axis_tvalid && !m_axis_tready`. No beat is dropped or duplicated under any `tready` pattern.
- **Completion:** `ctrl_done` is asserted in the cycle after the final output handshake. For N == 0 it is asserted in the cycle after `ctrl_start`.
- **Earliest restart:** a new `ctrl_start` is accepted in the cycle after the `ctrl_done` pulse, i.e. the first IDLE cycle.
- **Reset mid-operation:** `areset` asserted in any state empties the pipeline, drops in-flight beats and returns to IDLE with reset values. No `ctrl_done` is generated for the aborted run.
- **Simultaneous events:**
  - The final output handshake and a new input in the same cycle are impossible, because tready = 0 in DRAIN.
  - A stall and the last input accept in the same cycle: the accept wins only when the advance enable is 1.

## Configuration
- **`KVADD_STREAM_ALU_SAT_EN` defined:** mode 2 performs the saturating unsigned add.
- **`KVADD_STREAM_ALU_SAT_EN` undefined:** the saturation logic is removed, and mode 2 behaves identically to mode 0 (wrapping add).

## Test plan
Defaults for all scenarios: 512-bit data, 32-bit lanes, 2 pipeline stages.
- **Basic add:** size = 256, mode 0, c = 5, lane j of beat k = 16k + j, `m_axis_tready` = 1.
  - Lanes = 16k + j + 5.
  - `m_axis_tlast` on beat 3 only.
  - `ctrl_done` pulses one cycle after the 4th output handshake.
  - `stat_tlast_err` = 0 (input `tlast` on beat 3).
- **Rounding and zero size:**
  - size = 100: exactly 2 beats accepted, and `s_axis_tready` = 0 afterwards.
  - size = 0: no tready, and `ctrl_done` is asserted in the cycle after `ctrl_start`.
- **Arithmetic corners:**
  - Mode 1, x = 3, c = 5: result 0xFFFFFFFE.
  - Mode 2, x = 0xFFFFFFF0, c = 0x20: result 0xFFFFFFFF with the macro defined, 0x00000010 without it.
  - Mode 3: output equals input.
- **Backpressure:** 64 beats with a pseudo-random `m_axis_tready` (50% duty).
  - Output data sequence identical to the reference model; no loss or duplication.
  - Data held stable while stalled.
- **`tlast` checking:** size = 512 with input `tlast` on beat 2.
  - `stat_tlast_err` = 1 after beat 2.
  - Output `tlast` still on beat 7.
  - Flag cleared by the next `ctrl_start`.
- **Reset mid-run:** `areset` pulsed after 3 of 8 beats.
  - All outputs return to 0 the same cycle, with no `ctrl_done`.
  - A subsequent size = 128 run completes normally.

Source files
------------

// File: rtl/kvadd_stream_alu.sv
// Multi-lane streaming ALU stage: lane-wise add/sub/sat/pass against a latched constant,
// with self-generated tlast and a completion pulse. Optional macro: KVADD_STREAM_ALU_SAT_EN.
module kvadd_stream_alu #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_LANE_WIDTH       = 32,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_PIPE_STAGES      = 2
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          ctrl_start,
  output logic                          ctrl_done,
  input  logic [1:0]                    ctrl_mode,
  input  logic [C_LANE_WIDTH-1:0]       ctrl_constant,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          stat_tlast_err
);

  localparam int DW    = C_AXIS_TDATA_WIDTH;
  localparam int LW    = C_LANE_WIDTH;
  localparam int XW    = C_XFER_SIZE_WIDTH;
  localparam int PS    = C_PIPE_STAGES;
  localparam int LANES = DW / LW;

  localparam logic [XW-1:0] BYTES_PER_BEAT = XW'(DW / 8);
  localparam logic [XW-1:0] ONE_X          = XW'(1);
  localparam logic [XW-1:0] ZERO_X         = XW'(0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic [LW-1:0] lane_op(input logic [1:0]    mode,
                                            input logic [LW-1:0] x,
                                            input logic [LW-1:0] c);
`ifdef KVADD_STREAM_ALU_SAT_EN
    logic [LW:0] sat_sum;
    sat_sum = {1'b0, x} + {1'b0, c};
`endif
    case (mode)
      2'd0: lane_op = x + c;
      2'd1: lane_op = x - c;
`ifdef KVADD_STREAM_ALU_SAT_EN
      2'd2: lane_op = sat_sum[LW] ? {LW{1'b1}} : sat_sum[LW-1:0];
`else
      2'd2: lane_op = x + c;
`endif
      2'd3: lane_op = x;
      default: lane_op = x;
    endcase
  endfunction

  logic [1:0]    state_r;
  logic [1:0]    mode_r;
  logic [LW-1:0] const_r;
  logic [XW-1:0] n_r;
  logic [XW-1:0] in_cnt_r;
  logic          err_r;
  logic          done_r;

  logic          vld_r  [PS];
  logic [DW-1:0] data_r [PS];
  logic          last_r [PS];

  logic [XW-1:0] n_s;
  logic          rem_nz_s;
  logic          adv_s;
  logic          in_hs_s;
  logic          out_hs_s;
  logic          beat_last_s;
  logic [DW-1:0] alu_data_s;

  // Ceil division written as quotient plus remainder flag so the maximum size cannot overflow.
  assign rem_nz_s    = (ctrl_xfer_size_in_bytes % BYTES_PER_BEAT) != ZERO_X;
  assign n_s         = (ctrl_xfer_size_in_bytes / BYTES_PER_BEAT) + XW'(rem_nz_s);

  assign adv_s       = !vld_r[PS-1] || m_axis_tready;
  assign s_axis_tready = (state_r == ST_RUN) && adv_s;
  assign in_hs_s     = s_axis_tvalid && s_axis_tready;
  assign out_hs_s    = vld_r[PS-1] && m_axis_tready;
  assign beat_last_s = (in_cnt_r == (n_r - ONE_X));

  assign m_axis_tvalid  = vld_r[PS-1];
  assign m_axis_tdata   = data_r[PS-1];
  assign m_axis_tlast   = last_r[PS-1];
  assign ctrl_done      = done_r;
  assign stat_tlast_err = err_r;

  // Lane-wise arithmetic on the incoming beat using the latched mode and constant.
  always_comb begin
    alu_data_s = '0;
    for (int i = 0; i < LANES; i++) begin
      alu_data_s[i*LW +: LW] = lane_op(mode_r, s_axis_tdata[i*LW +: LW], const_r);
    end
  end

  // Run control: latching at start, input beat counting, tlast checking and the done pulse.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r  <= ST_IDLE;
      mode_r   <= 2'd0;
      const_r  <= '0;
      n_r      <= ZERO_X;
      in_cnt_r <= ZERO_X;
      err_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (ctrl_start) begin
            mode_r   <= ctrl_mode;
            const_r  <= ctrl_constant;
            n_r      <= n_s;
            in_cnt_r <= ZERO_X;
            err_r    <= 1'b0;
            state_r  <= (n_s == ZERO_X) ? ST_DONE : ST_RUN;
            done_r   <= (n_s == ZERO_X);
          end
        end
        ST_RUN: begin
          if (in_hs_s) begin
            in_cnt_r <= in_cnt_r + ONE_X;
            if (s_axis_tlast != beat_last_s) begin
              err_r <= 1'b1;
            end
            if (beat_last_s) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (out_hs_s && m_axis_tlast) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Lock-step pipeline: every stage moves only on the global advance enable; bubbles are kept.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < PS; i++) begin
        vld_r[i]  <= 1'b0;
        data_r[i] <= '0;
        last_r[i] <= 1'b0;
      end
    end else if (adv_s) begin
      vld_r[0]  <= in_hs_s;
      data_r[0] <= alu_data_s;
      last_r[0] <= in_hs_s && beat_last_s;
      for (int i = 1; i < PS; i++) begin
        vld_r[i]  <= vld_r[i-1];
        data_r[i] <= data_r[i-1];
        last_r[i] <= last_r[i-1];
      end
    end
  end

endmodule

// File: tb/tb_kvadd_stream_alu.sv
// Scoreboard bench for kvadd_stream_alu (default parameters); honours KVADD_STREAM_ALU_SAT_EN.
module tb_kvadd_stream_alu;

  logic         aclk;
  logic         areset;
  logic         ctrl_start;
  logic         ctrl_done;
  logic [1:0]   ctrl_mode;
  logic [31:0]  ctrl_constant;
  logic [31:0]  ctrl_xfer_size_in_bytes;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [511:0] s_axis_tdata;
  logic         s_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [511:0] m_axis_tdata;
  logic         m_axis_tlast;
  logic         stat_tlast_err;

  int checks = 0;
  int errors = 0;
  logic [512:0] exp_q [$];

  kvadd_stream_alu dut (
    .aclk                    (aclk),
    .areset                  (areset),
    .ctrl_start              (ctrl_start),
    .ctrl_done               (ctrl_done),
    .ctrl_mode               (ctrl_mode),
    .ctrl_constant           (ctrl_constant),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .s_axis_tvalid           (s_axis_tvalid),
    .s_axis_tready           (s_axis_tready),
    .s_axis_tdata            (s_axis_tdata),
    .s_axis_tlast            (s_axis_tlast),
    .m_axis_tvalid           (m_axis_tvalid),
    .m_axis_tready           (m_axis_tready),
    .m_axis_tdata            (m_axis_tdata),
    .m_axis_tlast            (m_axis_tlast),
    .stat_tlast_err          (stat_tlast_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [31:0] ref_lane(input logic [1:0] mode, input logic [31:0] x,
                                           input logic [31:0] c);
    longint s;
    s = longint'(x) + longint'(c);
    case (mode)
      2'd0: ref_lane = 32'(s);
      2'd1: ref_lane = 32'(longint'(x) - longint'(c) + 64'h1_0000_0000);
`ifdef KVADD_STREAM_ALU_SAT_EN
      2'd2: ref_lane = (s > 64'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
`else
      2'd2: ref_lane = 32'(s);
`endif
      default: ref_lane = x;
    endcase
  endfunction

  function automatic logic [511:0] beat_data(input logic [31:0] x0, input int k);
    for (int j = 0; j < 16; j++) beat_data[j*32 +: 32] = x0 + 32'(16 * k + j);
  endfunction

  // One transfer: drive at negedge, resolve the handshakes of the coming posedge, score outputs.
  task automatic run_xfer(input int size, input logic [1:0] mode, input logic [31:0] c,
                          input logic [31:0] x0, input int tlast_beat, input bit bp,
                          input int abort_after, output int lat);
    int n, acc, outs, first_in, first_out;
    bit done_exp, fin, hold, err_exp;
    logic [511:0] hold_data, xin, xexp;
    logic hold_last;
    logic [512:0] e;
    n = (size + 63) / 64;
    acc = 0; outs = 0; first_in = -1; first_out = -1; lat = -1;
    done_exp = (n == 0); fin = 1'b0; hold = 1'b0; err_exp = 1'b0;
    hold_data = '0; hold_last = 1'b0;
    exp_q.delete();
    ctrl_mode = mode; ctrl_constant = c; ctrl_xfer_size_in_bytes = 32'(size);
    ctrl_start = 1'b1; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    @(negedge aclk);
    ctrl_start = 1'b0;
    ctrl_mode = ~mode; ctrl_constant = ~c; ctrl_xfer_size_in_bytes = 32'hFFFF_FFFF;
    checks++;
    if (stat_tlast_err !== 1'b0) begin
      errors++; $display("FAIL err_clear_at_start: got %b want 0", stat_tlast_err);
    end
    for (int it = 0; it < 20 * n + 40 && !fin; it++) begin
      if (abort_after > 0 && acc == abort_after) begin
        areset = 1'b1;
        #1;
        checks++;
        if ({m_axis_tvalid, s_axis_tready, m_axis_tlast, ctrl_done, stat_tlast_err} !== 5'b0 ||
            m_axis_tdata !== 512'd0) begin
          errors++;
          $display("FAIL abort_outputs: got v%b r%b l%b d%b e%b data %h want all 0", m_axis_tvalid,
                   s_axis_tready, m_axis_tlast, ctrl_done, stat_tlast_err, m_axis_tdata);
        end
        @(negedge aclk);
        areset = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge aclk);
          checks++;
          if (ctrl_done !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            errors++; $display("FAIL abort_quiet: got done %b valid %b want 0 0", ctrl_done, m_axis_tvalid);
          end
        end
        s_axis_tvalid = 1'b0;
        exp_q.delete();
        return;
      end
      checks++;
      if (ctrl_done !== done_exp) begin
        errors++; $display("FAIL done_timing it%0d: got %b want %b", it, ctrl_done, done_exp);
      end
      if (ctrl_done === 1'b1) fin = 1'b1;
      if (hold) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold_data || m_axis_tlast !== hold_last) begin
          errors++; $display("FAIL stall_stable it%0d: got v%b l%b %h want v1 l%b %h", it, m_axis_tvalid,
                             m_axis_tlast, m_axis_tdata, hold_last, hold_data);
        end
      end
      if (m_axis_tvalid === 1'b1 && first_out < 0) first_out = it;
      if (!fin) begin
        s_axis_tvalid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_axis_tdata  = beat_data(x0, acc);
        s_axis_tlast  = (acc == tlast_beat);
        m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        done_exp = 1'b0;
        if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL extra_output: got %h want none", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (m_axis_tdata !== e[511:0] || m_axis_tlast !== e[512]) begin
              errors++; $display("FAIL out_beat%0d: got l%b %h want l%b %h", outs, m_axis_tlast,
                                 m_axis_tdata, e[512], e[511:0]);
            end
            if (e[512]) done_exp = 1'b1;
          end
          outs++;
        end
        hold = (m_axis_tvalid === 1'b1) && !m_axis_tready;
        hold_data = m_axis_tdata; hold_last = m_axis_tlast;
        if (s_axis_tvalid && s_axis_tready === 1'b1) begin
          if (acc >= n) begin
            checks++; errors++; $display("FAIL overrun: got beat %0d accepted want at most %0d", acc, n);
          end else begin
            xin = s_axis_tdata;
            for (int j = 0; j < 16; j++) xexp[j*32 +: 32] = ref_lane(mode, xin[j*32 +: 32], c);
            exp_q.push_back({(acc == n - 1), xexp});
            if (s_axis_tlast != (acc == n - 1)) err_exp = 1'b1;
          end
          if (first_in < 0) first_in = it;
          acc++;
        end
        @(negedge aclk);
      end
    end
    checks++;
    if (!fin) begin
      errors++; $display("FAIL timeout: got no ctrl_done want done after %0d beats", n);
    end
    checks++;
    if (acc != n || outs != n || exp_q.size() != 0) begin
      errors++; $display("FAIL beat_count: got in %0d out %0d left %0d want %0d %0d 0", acc, outs,
                         exp_q.size(), n, n);
    end
    checks++;
    if (stat_tlast_err !== err_exp || s_axis_tready !== 1'b0) begin
      errors++; $display("FAIL end_state: got err %b ready %b want %b 0", stat_tlast_err, s_axis_tready, err_exp);
    end
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    @(negedge aclk);
    checks++;
    if (ctrl_done !== 1'b0) begin
      errors++; $display("FAIL done_one_cycle: got %b want 0", ctrl_done);
    end
    if (first_in >= 0 && first_out >= 0) lat = first_out - first_in;
  endtask

  task automatic test_reset();
    areset = 1'b1; ctrl_start = 1'b0; ctrl_mode = 2'd0; ctrl_constant = 32'd0;
    ctrl_xfer_size_in_bytes = 32'd0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    repeat (2) @(negedge aclk);
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, ctrl_done, stat_tlast_err} !== 5'b0 ||
        m_axis_tdata !== 512'd0) begin
      errors++; $display("FAIL reset_values: got r%b v%b l%b d%b e%b data %h want 0", s_axis_tready,
                         m_axis_tvalid, m_axis_tlast, ctrl_done, stat_tlast_err, m_axis_tdata);
    end
    areset = 1'b0;
    @(negedge aclk);
  endtask

  task automatic test_basic_add();
    int lat;
    run_xfer(256, 2'd0, 32'd5, 32'd0, 3, 1'b0, 0, lat);
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL latency: got %0d want 2", lat);
    end
  endtask

  task automatic test_rounding_zero();
    int lat;
    run_xfer(100, 2'd0, 32'd7, 32'h100, 1, 1'b0, 0, lat);
    run_xfer(0, 2'd0, 32'd7, 32'h0, -1, 1'b0, 0, lat);
  endtask

  task automatic test_arith();
    int lat;
    run_xfer(64, 2'd1, 32'd5, 32'd3, 0, 1'b0, 0, lat);
    run_xfer(128, 2'd2, 32'h20, 32'hFFFF_FFF0, 1, 1'b0, 0, lat);
    run_xfer(192, 2'd3, 32'h1234, $urandom, 2, 1'b0, 0, lat);
  endtask

  task automatic test_backpressure();
    int lat;
    run_xfer(64 * 64, 2'd0, 32'hDEAD_0001, $urandom, 63, 1'b1, 0, lat);
  endtask

  task automatic test_tlast_err();
    int lat;
    run_xfer(512, 2'd0, 32'd1, 32'd0, 2, 1'b0, 0, lat);
    checks++;
    if (stat_tlast_err !== 1'b1) begin
      errors++; $display("FAIL tlast_err_sticky: got %b want 1", stat_tlast_err);
    end
    run_xfer(64, 2'd0, 32'd1, 32'd0, 0, 1'b0, 0, lat);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    run_xfer(512, 2'd0, 32'd9, 32'd0, 7, 1'b0, 3, lat);
    run_xfer(128, 2'd1, 32'd9, 32'd50, 1, 1'b0, 0, lat);
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_rounding_zero();
    test_arith();
    test_backpressure();
    test_tlast_err();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
